// File: rtl/uart_fifo_periph.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, a run-time baud divisor and a registered level interrupt.
// Both serial FSMs reload their bit timer from the divisor at every bit boundary.
module uart_fifo_periph #(
  parameter int CLK_DIV    = 434,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  rw,
  input  logic [3:0]            address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  irq,
  output logic                  tx,
  input  logic                  rx
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0] RX_FULL_CNT = (RAW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic [2:0]  r_ctrl;
  logic [15:0] r_div;
  logic        r_overrun, r_frame_err, r_irq;

  logic w_wr, w_rd, w_unused;
  assign w_wr     = ce & rw;
  assign w_rd     = ce & ~rw;
  assign w_unused = ^data_in[DATA_WIDTH-1:16];

  // ---------------- TX FIFO ----------------
  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [TAW-1:0] r_tx_wp, r_tx_rp;
  logic [TAW:0]   r_tx_count;
  logic           w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;

  assign w_tx_full  = (r_tx_count == TX_FULL_CNT);
  assign w_tx_empty = (r_tx_count == '0);
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign w_tx_push  = w_wr & (address == 4'd0) & (~w_tx_full | w_tx_pop);

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= data_in[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  uart_state_t r_tx_state, w_tx_next;
  logic [15:0] r_tx_tmr;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        w_tx_tick;

  assign w_tx_tick = (r_tx_tmr == 16'd0);

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      S_IDLE:  if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_next = S_START; end
      S_START: if (w_tx_tick) w_tx_next = S_DATA;
      S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = S_STOP;
      S_STOP:  if (w_tx_tick) begin
                 if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_next = S_START; end
                 else w_tx_next = S_IDLE;
               end
      default: w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= S_IDLE; r_tx_tmr <= '0; r_tx_bit <= '0; r_tx_shift <= 8'hFF;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_pop) begin
        r_tx_tmr   <= r_div - 16'd1;
        r_tx_shift <= r_tx_mem[r_tx_rp];
      end else if (r_tx_state != S_IDLE) begin
        if (w_tx_tick) begin
          r_tx_tmr <= r_div - 16'd1;
          if (r_tx_state == S_START) r_tx_bit <= 3'd0;
          if (r_tx_state == S_DATA) begin
            r_tx_shift <= {1'b1, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 1'b1;
          end
        end else begin
          r_tx_tmr <= r_tx_tmr - 16'd1;
        end
      end
    end
  end

  always_comb begin
    case (r_tx_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = r_tx_shift[0];
      default: tx = 1'b1;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [RAW-1:0] r_rx_wp, r_rx_rp;
  logic [RAW:0]   r_rx_count;
  logic           w_rx_full, w_rx_empty, w_rx_push_req, w_rx_push, w_rx_pop, w_rx_ovr_set;
  logic [7:0]     r_rx_shift;

  assign w_rx_full    = (r_rx_count == RX_FULL_CNT);
  assign w_rx_empty   = (r_rx_count == '0);
  assign w_rx_pop     = w_rd & (address == 4'd1) & ~w_rx_empty;
  assign w_rx_push    = w_rx_push_req & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr_set = w_rx_push_req & w_rx_full & ~w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // ---------------- RX FSM ----------------
  uart_state_t r_rx_state, w_rx_next;
  logic [15:0] r_rx_tmr;
  logic [2:0]  r_rx_bit;
  logic        r_rx_s1, r_rx_s2, r_rx_hold, w_rx_tick, w_rx_ferr;

  assign w_rx_tick = (r_rx_tmr == 16'd0);

  always_comb begin
    w_rx_next     = r_rx_state;
    w_rx_push_req = 1'b0;
    w_rx_ferr     = 1'b0;
    case (r_rx_state)
      // r_rx_hold keeps a broken frame's low line from restarting reception.
      S_IDLE:  if (!r_rx_s2 && !r_rx_hold) w_rx_next = S_START;
      S_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = S_STOP;
      S_STOP:  if (w_rx_tick) begin
                 w_rx_next     = S_IDLE;
                 w_rx_push_req = r_rx_s2;
                 w_rx_ferr     = ~r_rx_s2;
               end
      default: w_rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_hold <= 1'b0;
      r_rx_state <= S_IDLE; r_rx_tmr <= '0; r_rx_bit <= '0; r_rx_shift <= '0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_next;
      if (w_rx_ferr)    r_rx_hold <= 1'b1;
      else if (r_rx_s2) r_rx_hold <= 1'b0;
      if (r_rx_state == S_IDLE) begin
        r_rx_tmr <= {1'b0, r_div[15:1]} - 16'd1;
        r_rx_bit <= 3'd0;
      end else if (w_rx_tick) begin
        r_rx_tmr <= r_div - 16'd1;
        if (r_rx_state == S_DATA) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 1'b1;
        end
      end else begin
        r_rx_tmr <= r_rx_tmr - 16'd1;
      end
    end
  end

  // ---------------- Registers, flags, interrupt ----------------
  logic w_st_wr, w_tx_busy;
  assign w_st_wr   = w_wr & (address == 4'd2);
  assign w_tx_busy = (r_tx_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0; r_div <= 16'(CLK_DIV);
      r_overrun <= 1'b0; r_frame_err <= 1'b0; r_irq <= 1'b0;
    end else begin
      if (w_wr && address == 4'd3) r_ctrl <= data_in[2:0];
      if (w_wr && address == 4'd4) r_div <= (data_in[15:0] < 16'd4) ? 16'd4 : data_in[15:0];
      if (w_rx_ovr_set)                r_overrun <= 1'b1;
      else if (w_st_wr && data_in[5])  r_overrun <= 1'b0;
      if (w_rx_ferr)                   r_frame_err <= 1'b1;
      else if (w_st_wr && data_in[6])  r_frame_err <= 1'b0;
      r_irq <= (r_ctrl[0] & w_tx_empty & ~w_tx_busy) | (r_ctrl[1] & ~w_rx_empty) |
               (r_ctrl[2] & (r_overrun | r_frame_err));
    end
  end

  assign irq = r_irq;

  always_comb begin
    data_out = '0;
    if (ce) begin
      case (address)
        4'd1:    if (!w_rx_empty) data_out[7:0] = r_rx_mem[r_rx_rp];
        4'd2:    data_out[6:0] = {r_frame_err, r_overrun, w_rx_full, ~w_rx_empty,
                                  w_tx_busy, w_tx_empty, ~w_tx_full};
        4'd3:    data_out[2:0] = r_ctrl;
        4'd4:    data_out[15:0] = r_div;
        default: data_out = '0;
      endcase
    end
  end
endmodule
